// File: rtl/pma_scan_ctrl.sv
// Sequential PMA classifier: walks the NonIdempotent/Execute/Cached rule tables one index per cycle.
// Optional early termination once every class is resolved: define PMA_SCAN_EARLY_EXIT_EN.
module pma_scan_hit (
  input  logic [63:0] addr,
  input  logic [63:0] base,
  input  logic [63:0] len,
  input  logic        en,
  output logic        hit
);
  logic [64:0] lim;

  // 65-bit limit so a region ending at the top of the address space cannot wrap
  assign lim = {1'b0, base} + {1'b0, len};
  assign hit = en && (addr >= base) && ({1'b0, addr} < lim);
endmodule

module pma_scan_ctrl #(
  parameter int unsigned                   NrMaxRules            = 16,
  parameter int unsigned                   AddrW                 = 64,
  parameter int unsigned                   NrNonIdempotentRules  = 0,
  parameter logic [NrMaxRules-1:0][63:0]   NonIdempotentAddrBase = '0,
  parameter logic [NrMaxRules-1:0][63:0]   NonIdempotentLength   = '0,
  parameter int unsigned                   NrExecuteRegionRules  = 0,
  parameter logic [NrMaxRules-1:0][63:0]   ExecuteRegionAddrBase = '0,
  parameter logic [NrMaxRules-1:0][63:0]   ExecuteRegionLength   = '0,
  parameter int unsigned                   NrCachedRegionRules   = 0,
  parameter logic [NrMaxRules-1:0][63:0]   CachedRegionAddrBase  = '0,
  parameter logic [NrMaxRules-1:0][63:0]   CachedRegionLength    = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [AddrW-1:0] req_addr_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_nonidem_o,
  output logic             rsp_exec_o,
  output logic             rsp_cached_o,
  output logic             busy_o
);
  localparam int unsigned IdxW = $clog2(NrMaxRules);
  localparam int unsigned N01  = (NrNonIdempotentRules > NrExecuteRegionRules) ?
                                 NrNonIdempotentRules : NrExecuteRegionRules;
  localparam int unsigned N    = (N01 > NrCachedRegionRules) ? N01 : NrCachedRegionRules;
  localparam bit          ExecNone = (NrExecuteRegionRules == 0);

  // class order: 0 = non-idempotent, 1 = execute, 2 = cached
  localparam logic [2:0][NrMaxRules-1:0][63:0] Base =
    {CachedRegionAddrBase, ExecuteRegionAddrBase, NonIdempotentAddrBase};
  localparam logic [2:0][NrMaxRules-1:0][63:0] Len =
    {CachedRegionLength, ExecuteRegionLength, NonIdempotentLength};
  localparam int unsigned Cnt [3] = '{NrNonIdempotentRules, NrExecuteRegionRules, NrCachedRegionRules};

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q;
  logic [63:0]     addr_q;
  logic [2:0]      flag_q;
  logic [2:0]      hit;
  logic            accept;
  logic            scan_end;

  for (genvar c = 0; c < 3; c++) begin : g_cls
    pma_scan_hit u_hit (
      .addr (addr_q),
      .base (Base[c][idx_q]),
      .len  (Len[c][idx_q]),
      .en   (32'(idx_q) < Cnt[c]),
      .hit  (hit[c])
    );
  end

`ifdef PMA_SCAN_EARLY_EXIT_EN
  logic [2:0] resolved;
  // a class with no rules left to check (incl. an empty exec table) is resolved by exhaustion
  for (genvar c = 0; c < 3; c++) begin : g_res
    assign resolved[c] = flag_q[c] | hit[c] | (32'(idx_q) + 32'd1 >= Cnt[c]);
  end
  assign scan_end = (32'(idx_q) == N - 1) || (&resolved);
`else
  assign scan_end = (32'(idx_q) == N - 1);
`endif

  assign accept = (state_q == IDLE) && req_valid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = (N == 0) ? DONE : SCAN;
      SCAN:    if (flush_i) state_d = IDLE;
               else if (scan_end) state_d = DONE;
      DONE:    if (flush_i || rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q  <= '0;
      flag_q <= '0;
      addr_q <= '0;
    end else if (accept) begin
      idx_q  <= '0;
      flag_q <= '0;
      addr_q <= 64'(req_addr_i);
    end else if (state_q == SCAN && !flush_i) begin
      flag_q <= flag_q | hit;
      if (!scan_end) idx_q <= idx_q + IdxW'(1);
    end
  end

  // flags are only presented while a result is being offered
  always_comb begin
    req_ready_o   = (state_q == IDLE);
    busy_o        = (state_q != IDLE);
    rsp_valid_o   = (state_q == DONE);
    rsp_nonidem_o = rsp_valid_o & flag_q[0];
    rsp_exec_o    = rsp_valid_o & (ExecNone | flag_q[1]);
    rsp_cached_o  = rsp_valid_o & flag_q[2];
  end
endmodule

// File: tb/tb_pma_scan_ctrl.sv
// Directed bench for pma_scan_ctrl: N=2 rule config plus an all-empty config instance.
module tb_pma_scan_ctrl;
  localparam logic [15:0][63:0] NI_BASE = '0;
  localparam logic [15:0][63:0] NI_LEN  = 1024'(64'h1000_0000);
  localparam logic [15:0][63:0] EX_BASE = 1024'({64'h8000_0000, 64'h0001_0000});
  localparam logic [15:0][63:0] EX_LEN  = 1024'({64'h4000_0000, 64'h0001_0000});
  localparam logic [15:0][63:0] CA_BASE = 1024'(64'h8000_0000);
  localparam logic [15:0][63:0] CA_LEN  = 1024'(64'h4000_0000);

  logic clk = 0;
  logic rst = 1, flush = 0, req_valid = 0, rsp_ready = 1;
  logic [63:0] req_addr = '0;
  logic req_ready, rsp_valid, nonidem, exec, cached, busy;
  logic z_req_valid = 0, z_rsp_ready = 1;
  logic z_req_ready, z_rsp_valid, z_nonidem, z_exec, z_cached, z_busy;
  logic [2:0] f, zf;
  int checks = 0, errors = 0;

  assign f  = {nonidem, exec, cached};
  assign zf = {z_nonidem, z_exec, z_cached};

  always #5 clk = ~clk;

  pma_scan_ctrl #(
    .NrNonIdempotentRules(1), .NonIdempotentAddrBase(NI_BASE), .NonIdempotentLength(NI_LEN),
    .NrExecuteRegionRules(2), .ExecuteRegionAddrBase(EX_BASE), .ExecuteRegionLength(EX_LEN),
    .NrCachedRegionRules(1),  .CachedRegionAddrBase(CA_BASE),  .CachedRegionLength(CA_LEN)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_nonidem_o(nonidem), .rsp_exec_o(exec), .rsp_cached_o(cached), .busy_o(busy)
  );

  pma_scan_ctrl u_zero (
    .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .req_valid_i(z_req_valid), .req_ready_o(z_req_ready),
    .req_addr_i(64'h1234), .rsp_valid_o(z_rsp_valid), .rsp_ready_i(z_rsp_ready),
    .rsp_nonidem_o(z_nonidem), .rsp_exec_o(z_exec), .rsp_cached_o(z_cached), .busy_o(z_busy)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  // issues one request, returns cycles from accepting edge to rsp_valid (-1 on timeout)
  task automatic do_req(input logic [63:0] a, output int lat);
    req_addr = a; req_valid = 1;
    step();
    req_valid = 0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin step(); lat++; end
    if (!rsp_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1; step(); step(); rst = 0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (f !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", f); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
  endtask

  task automatic test_basic();
    int lat;
    do_req(64'h8000_1000, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL basic_latency got %0d want 2", lat); end
    checks++; if (f !== 3'b011) begin errors++; $display("FAIL basic_flags got %b want 011", f); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_in_done got %b want 0", req_ready); end
    step();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++;
      $display("FAIL basic_return_idle got v=%b r=%b want v=0 r=1", rsp_valid, req_ready); end
  endtask

  task automatic test_boundaries();
    logic [63:0] addrs [3] = '{64'hBFFF_FFFF, 64'hC000_0000, 64'h100};
    logic [2:0]  exp   [3] = '{3'b011, 3'b000, 3'b100};
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_req(addrs[i], lat);
      checks++; if (lat !== 2 || f !== exp[i]) begin errors++;
        $display("FAIL boundary_%h got lat=%0d flags=%b want lat=2 flags=%b", addrs[i], lat, f, exp[i]); end
      step();
    end
  endtask

  task automatic test_backpressure();
    int lat, n;
    rsp_ready = 0;
    do_req(64'h8000_1000, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL bp_latency got %0d want 2", lat); end
    req_addr = 64'h100; req_valid = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (rsp_valid !== 1'b1 || f !== 3'b011 || req_ready !== 1'b0) begin errors++;
        $display("FAIL bp_hold_%0d got v=%b flags=%b r=%b want v=1 flags=011 r=0", i, rsp_valid, f, req_ready); end
    end
    rsp_ready = 1;
    step();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL bp_handshake got v=%b r=%b busy=%b want 0 1 0", rsp_valid, req_ready, busy); end
    step();
    req_valid = 0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_next_accept got busy=%b want 1", busy); end
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    checks++; if (n !== 2 || f !== 3'b100) begin errors++;
      $display("FAIL bp_second_req got lat=%0d flags=%b want lat=2 flags=100", n, f); end
    step();
  endtask

  task automatic test_flush();
    int lat, seen;
    req_addr = 64'h8000_1000; req_valid = 1;
    step();
    req_valid = 0;
    step();
    flush = 1;
    step();
    flush = 0;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL flush_idle got r=%b v=%b busy=%b want 1 0 0", req_ready, rsp_valid, busy); end
    seen = 0;
    for (int i = 0; i < 5; i++) begin step(); if (rsp_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_rsp got %0d responses want 0", seen); end
    do_req(64'hBFFF_FFFF, lat);
    checks++; if (lat !== 2 || f !== 3'b011) begin errors++;
      $display("FAIL flush_after got lat=%0d flags=%b want lat=2 flags=011", lat, f); end
    step();
    // a flush arriving with a request in IDLE must not block acceptance
    flush = 1; req_valid = 1; req_addr = 64'h100;
    step();
    flush = 0; req_valid = 0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_idle_accept got busy=%b want 1", busy); end
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_reset_mid();
    int seen;
    req_addr = 64'h8000_1000; req_valid = 1;
    step();
    req_valid = 0;
    rst = 1;
    step();
    rst = 0;
    checks++; if (rsp_valid !== 1'b0 || f !== 3'b000 || busy !== 1'b0 || req_ready !== 1'b1) begin errors++;
      $display("FAIL rst_mid got v=%b flags=%b busy=%b r=%b want 0 000 0 1", rsp_valid, f, busy, req_ready); end
    seen = 0;
    for (int i = 0; i < 5; i++) begin step(); if (rsp_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_stale got %0d responses want 0", seen); end
  endtask

  task automatic test_early_exit();
    int lat, exp_lat;
`ifdef PMA_SCAN_EARLY_EXIT_EN
    exp_lat = 1;
`else
    exp_lat = 2;
`endif
    do_req(64'h1_0000, lat);
    checks++; if (lat !== exp_lat || f !== 3'b110) begin errors++;
      $display("FAIL early_exit got lat=%0d flags=%b want lat=%0d flags=110", lat, f, exp_lat); end
    step();
  endtask

  task automatic test_zero_rules();
    checks++; if (z_rsp_valid !== 1'b0 || z_req_ready !== 1'b1) begin errors++;
      $display("FAIL zero_idle got v=%b r=%b want 0 1", z_rsp_valid, z_req_ready); end
    z_req_valid = 1;
    step();
    z_req_valid = 0;
    checks++; if (z_rsp_valid !== 1'b1 || zf !== 3'b010) begin errors++;
      $display("FAIL zero_rsp got v=%b flags=%b want v=1 flags=010", z_rsp_valid, zf); end
    step();
    checks++; if (z_busy !== 1'b0 || z_rsp_valid !== 1'b0) begin errors++;
      $display("FAIL zero_return got busy=%b v=%b want 0 0", z_busy, z_rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_early_exit();
    test_zero_rules();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
